// File: rtl/sum_splitter_pkg.sv
// Shared types and defaults for the sum_splitter datapath (S - A operand recovery).
package sum_splitter_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  // Payload carried by each pipeline stage, default operand width.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] b;
    logic                 borrow;
    logic                 p;
    logic                 q;
  } payload_t;

  localparam payload_t PAYLOAD_RST = '0;

  function automatic int unsigned payload_w(int unsigned width);
    return width + 32'd3;
  endfunction

endpackage

// File: rtl/sum_splitter_if.sv
// Valid/ready bus bundle for sum_splitter: operand input side and result output side.
interface sum_splitter_if
  import sum_splitter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_b;
  logic             out_borrow;
  logic             out_p;
  logic             out_q;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_s, in_a, out_ready,
    input  in_ready, out_valid, out_b, out_borrow, out_p, out_q, out_cnt
  );

  modport slave (
    input  in_valid, in_s, in_a, out_ready,
    output in_ready, out_valid, out_b, out_borrow, out_p, out_q, out_cnt
  );
endinterface

// File: rtl/sum_splitter_stage.sv
// One-entry valid/ready register slice; accepts while empty or draining in the same cycle.
module sum_splitter_stage
  import sum_splitter_pkg::*;
#(
  parameter type   data_t  = payload_t,
  parameter data_t RST_VAL = PAYLOAD_RST
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  up_valid,
  output logic  up_ready,
  input  data_t up_data,
  output logic  dn_valid,
  input  logic  dn_ready,
  output data_t dn_data
);

  logic load;

  always_comb begin
    up_ready = !dn_valid || dn_ready;
    load     = up_valid && up_ready;
  end

  // Data only changes on load, so it holds while the entry is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= RST_VAL;
    end else begin
      if (load) begin
        dn_valid <= 1'b1;
        dn_data  <= up_data;
      end else if (dn_ready) begin
        dn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sum_splitter.sv
// Recovers B = S - A with borrow and S[1:0] through a registered valid/ready pipeline.
// Define SUM_SPLITTER_PIPE2_EN for a second register stage (latency 2, capacity 2).
module sum_splitter
  import sum_splitter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sum_splitter_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic             borrow;
    logic             p;
    logic             q;
  } result_t;

  localparam result_t RESULT_RST = '0;

  logic [WIDTH:0]   diff;
  result_t          in_pl;
  result_t          out_pl;
  logic             out_valid;
  logic [CNT_W-1:0] cnt;

  // Extended difference: top bit is the borrow out of the WIDTH-bit subtract.
  always_comb begin
    diff         = {1'b0, bus.in_s} - {1'b0, bus.in_a};
    in_pl.b      = diff[WIDTH-1:0];
    in_pl.borrow = diff[WIDTH];
    in_pl.p      = bus.in_s[0];
    in_pl.q      = bus.in_s[1];
  end

`ifdef SUM_SPLITTER_PIPE2_EN
  logic    mid_valid;
  logic    mid_ready;
  result_t mid_pl;

  sum_splitter_stage #(.data_t(result_t), .RST_VAL(RESULT_RST)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (bus.in_valid),
    .up_ready (bus.in_ready),
    .up_data  (in_pl),
    .dn_valid (mid_valid),
    .dn_ready (mid_ready),
    .dn_data  (mid_pl)
  );

  sum_splitter_stage #(.data_t(result_t), .RST_VAL(RESULT_RST)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (mid_valid),
    .up_ready (mid_ready),
    .up_data  (mid_pl),
    .dn_valid (out_valid),
    .dn_ready (bus.out_ready),
    .dn_data  (out_pl)
  );
`else
  sum_splitter_stage #(.data_t(result_t), .RST_VAL(RESULT_RST)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (bus.in_valid),
    .up_ready (bus.in_ready),
    .up_data  (in_pl),
    .dn_valid (out_valid),
    .dn_ready (bus.out_ready),
    .dn_data  (out_pl)
  );
`endif

  // Delivered-result counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_valid && bus.out_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_b      = out_pl.b;
  assign bus.out_borrow = out_pl.borrow;
  assign bus.out_p      = out_pl.p;
  assign bus.out_q      = out_pl.q;
  assign bus.out_cnt    = cnt;

endmodule
